// File: rtl/note_player_pkg.sv
// rtl/note_player_pkg.sv - shared state encodings and width default for note_player
package note_player_pkg;

  localparam int PERIOD_W_DEFAULT = 8;

  // One-hot state encodings; all-zero is the reset state
  typedef enum logic [3:0] {
    STATE_RESET     = 4'b0000,
    STATE_LOAD_HIGH = 4'b1000,
    STATE_WAIT_HIGH = 4'b0100,
    STATE_LOAD_LOW  = 4'b0010,
    STATE_WAIT_LOW  = 4'b0001
  } state_e;

endpackage

// File: rtl/note_player_counter.sv
// rtl/note_player_counter.sv - loadable down-counter that saturates at zero
module note_player_counter
  import note_player_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                dec,
  input  logic [PERIOD_W-1:0] din,
  output logic [PERIOD_W-1:0] count,
  output logic                zero
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  assign zero = (count == '0);

  // Decrement is gated on !zero so a long wait can never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (dec && !zero) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - square-wave tone generator; NOTE_PLAYER_REST_EN makes period 0 a rest
module note_player
  import note_player_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  output logic [3:0]          state,
  output logic                note
);

  state_e                state_q;
  state_e                state_d;
  logic                  load;
  logic                  dec;
  logic                  zero;
  logic [PERIOD_W-1:0]   count_unused;
  logic                  note_raw;

  note_player_counter #(
    .PERIOD_W (PERIOD_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst),
    .load  (load),
    .dec   (dec),
    .din   (period),
    .count (count_unused),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Non-one-hot encodings fall through to default and recover via RESET
  always_comb begin
    state_d = STATE_RESET;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      STATE_RESET:     state_d = STATE_LOAD_HIGH;
      STATE_LOAD_HIGH: begin
        load    = 1'b1;
        state_d = STATE_WAIT_HIGH;
      end
      STATE_WAIT_HIGH: begin
        dec     = 1'b1;
        state_d = zero ? STATE_LOAD_LOW : STATE_WAIT_HIGH;
      end
      STATE_LOAD_LOW:  begin
        load    = 1'b1;
        state_d = STATE_WAIT_LOW;
      end
      STATE_WAIT_LOW:  begin
        dec     = 1'b1;
        state_d = zero ? STATE_LOAD_HIGH : STATE_WAIT_LOW;
      end
      default:         state_d = STATE_RESET;
    endcase
  end

  assign state    = state_q;
  assign note_raw = (state_q == STATE_LOAD_HIGH) || (state_q == STATE_WAIT_HIGH);

`ifdef NOTE_PLAYER_REST_EN
  logic [PERIOD_W-1:0] period_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= '0;
    end else if (load) begin
      period_q <= period;
    end
  end

  assign note = note_raw && (period_q != '0);
`else
  assign note = note_raw;
`endif

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - randomized self-checking bench for note_player
module tb_note_player;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] period = 8'd0;
  logic [3:0] state;
  logic       note;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase of the tone plus cycles left in the current wait
  bit m_in_reset = 1'b1;
  bit m_high     = 1'b0;
  bit m_load     = 1'b0;
  int m_left     = 0;
  int m_latched  = 0;

  note_player dut (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .state  (state),
    .note   (note)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_in_reset = 1'b1;
    m_latched  = 0;
  endtask

  task automatic model_step();
    if (!rst) begin
      model_reset();
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_high     = 1'b1;
      m_load     = 1'b1;
    end else if (m_load) begin
      m_load    = 1'b0;
      m_left    = int'(period) + 1;
      m_latched = int'(period);
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_high = !m_high;
        m_load = 1'b1;
      end
    end
  endtask

  function automatic logic [3:0] m_state();
    if (m_in_reset) return 4'b0000;
    if (m_high) return m_load ? 4'b1000 : 4'b0100;
    return m_load ? 4'b0010 : 4'b0001;
  endfunction

  function automatic logic m_note();
`ifdef NOTE_PLAYER_REST_EN
    return !m_in_reset && m_high && (m_latched != 0);
`else
    return !m_in_reset && m_high;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [7:0] p);
    @(negedge clk);
    rst    = 1'b0;
    period = p;
    #1;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] seq [9];
    seq = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0010,
            4'b0001, 4'b0001, 4'b0001, 4'b1000};
    rst    = 1'b0;
    period = 8'd2;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (state !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 0000", state);
    end
    n_checks++;
    if (note !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_note: got %b expected 0", note);
    end
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (state !== seq[i]) begin
        n_fail++;
        $display("FAIL basic_state[%0d]: got %b expected %b", i, state, seq[i]);
      end
      n_checks++;
      if (note !== m_note()) begin
        n_fail++;
        $display("FAIL basic_note[%0d]: got %b expected %b", i, note, m_note());
      end
    end
  endtask

  task automatic test_period_zero();
    logic [3:0] seq [4];
    seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    apply_reset(8'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (state !== seq[i % 4]) begin
        n_fail++;
        $display("FAIL p0_state[%0d]: got %b expected %b", i, state, seq[i % 4]);
      end
      n_checks++;
      if (note !== m_note()) begin
        n_fail++;
        $display("FAIL p0_note[%0d]: got %b expected %b", i, note, m_note());
      end
    end
  endtask

  task automatic test_mid_wait_change();
    int cnt;
    apply_reset(8'd3);
    tick();
    tick();
    period = 8'd1;
    cnt = 1;
    for (int i = 0; i < 300 && state == 4'b0100; i++) begin
      tick();
      if (state == 4'b0100) cnt++;
    end
    n_checks++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL midwait_high_len: got %0d expected 4", cnt);
    end
    n_checks++;
    if (state !== 4'b0010) begin
      n_fail++;
      $display("FAIL midwait_load_low: got %b expected 0010", state);
    end
    tick();
    cnt = 0;
    for (int i = 0; i < 300 && state == 4'b0001; i++) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL midwait_low_len: got %0d expected 2", cnt);
    end
    n_checks++;
    if (state !== 4'b1000) begin
      n_fail++;
      $display("FAIL midwait_next_high: got %b expected 1000", state);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset(8'd5);
    for (int i = 0; i < 50 && state != 4'b0001; i++) tick();
    n_checks++;
    if (state !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmw_reach_wait_low: got %b expected 0001", state);
    end
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (state !== 4'b0000 || note !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_async: got state %b note %b expected 0000/0", state, note);
    end
    tick();
    n_checks++;
    if (state !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmw_held: got %b expected 0000", state);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (state !== 4'b1000 || note !== m_note()) begin
      n_fail++;
      $display("FAIL rmw_release: got state %b note %b expected 1000/%b", state, note, m_note());
    end
  endtask

  task automatic test_max_period();
    int cnt;
    apply_reset(8'd255);
    tick();
    tick();
    cnt = 1;
    for (int i = 0; i < 400 && state == 4'b0100; i++) begin
      tick();
      if (state == 4'b0100) cnt++;
    end
    n_checks++;
    if (cnt != 256) begin
      n_fail++;
      $display("FAIL max_high_len: got %0d expected 256", cnt);
    end
    n_checks++;
    if (state !== 4'b0010) begin
      n_fail++;
      $display("FAIL max_load_low: got %b expected 0010", state);
    end
  endtask

  task automatic test_random();
    apply_reset(8'($urandom_range(0, 6)));
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 5));
      end
      tick();
      n_checks++;
      if (state !== m_state()) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got %b expected %b", i, state, m_state());
      end
      n_checks++;
      if (note !== m_note()) begin
        n_fail++;
        $display("FAIL rand_note[%0d]: got %b expected %b", i, note, m_note());
      end
`ifdef NOTE_PLAYER_REST_EN
      if (m_latched == 0) begin
        n_checks++;
        if (note !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_rest[%0d]: got %b expected 0", i, note);
        end
      end
`endif
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_period_zero();
    test_mid_wait_change();
    test_reset_mid_wait();
    test_max_period();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
